mcu_command_sequencer: RTL and testbench

Frame-level command decoder between the SPIController byte interface and the renderer core. It parses each chip-select framed transaction into opcode, length and payload. It then dispatches register writes and reads, forwards stream payload to a downstream sink over valid/ready, and returns a status or read byte on the SPI response path.

---
 rtl/mcu_cmd_pkg.sv | 40 ++++
 rtl/mcu_stream_buffer.sv | 44 ++++
 rtl/mcu_command_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_mcu_command_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mcu_cmd_pkg.sv
// rtl/mcu_cmd_pkg.sv - opcodes, expected lengths, FSM encoding and status bit positions
package mcu_cmd_pkg;

  localparam logic [7:0] OP_STATUS    = 8'h01;
  localparam logic [7:0] OP_WRITE_REG = 8'h02;
  localparam logic [7:0] OP_READ_REG  = 8'h03;
  localparam logic [7:0] OP_STREAM    = 8'h10;

  localparam logic [7:0] LEN_STATUS    = 8'd0;
  localparam logic [7:0] LEN_WRITE_REG = 8'd2;
  localparam logic [7:0] LEN_READ_REG  = 8'd1;

  localparam int STS_FRAME_ERR    = 0;
  localparam int STS_OVERFLOW     = 1;
  localparam int STS_STREAM_VALID = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_LENGTH,
    ST_PAYLOAD,
    ST_DRAIN
  } state_t;

  function automatic logic opcode_known(input logic [7:0] op);
    return (op == OP_STATUS) || (op == OP_WRITE_REG) ||
           (op == OP_READ_REG) || (op == OP_STREAM);
  endfunction

  // STREAM accepts any length, so it is never a mismatch.
  function automatic logic length_ok(input logic [7:0] op, input logic [7:0] len);
    case (op)
      OP_STATUS:    return len == LEN_STATUS;
      OP_WRITE_REG: return len == LEN_WRITE_REG;
      OP_READ_REG:  return len == LEN_READ_REG;
      default:      return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mcu_stream_buffer.sv
// rtl/mcu_stream_buffer.sv - single-entry valid/ready holding register with overflow pulse
module mcu_stream_buffer (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       overflow
);

  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;

  // A full buffer that drains this cycle can take the new byte directly.
  assign overflow = in_valid && valid_q && !out_ready;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (in_valid && (!valid_q || out_ready)) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/mcu_command_sequencer.sv
// rtl/mcu_command_sequencer.sv - frame parser dispatching register, status and stream commands
module mcu_command_sequencer
  import mcu_cmd_pkg::*;
#(
  parameter int         REG_ADDR_W = 4,
  parameter logic [3:0] STATUS_ID  = 4'hA
) (
  input  logic                  i_master_clk,
  input  logic                  i_reset,
  input  logic [7:0]            i_master_data,
  input  logic                  i_master_data_valid,
  input  logic                  i_master_start,
  input  logic                  i_master_end,
  output logic [7:0]            o_response_data,
  output logic                  o_response_data_valid,
  output logic                  o_reg_wr_en,
  output logic [REG_ADDR_W-1:0] o_reg_addr,
  output logic [7:0]            o_reg_wr_data,
  input  logic [7:0]            i_reg_rd_data,
  output logic [7:0]            o_stream_data,
  output logic                  o_stream_valid,
  input  logic                  i_stream_ready
);

  state_t                state_q, state_d;
  logic [7:0]            opcode_q, opcode_d;
  logic [7:0]            count_q, count_d;
  logic                  frame_error_q, frame_error_d;
  logic                  overflow_q, overflow_d;
  logic                  rd_pending_q, rd_pending_d;
  logic [7:0]            resp_data_q, resp_data_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]            wr_data_q, wr_data_d;

  logic       push_valid;
  logic       buf_overflow;
  logic       set_err;
  logic       status_read;
  logic       addr_bad;
  logic [7:0] status_byte;
  state_t     cur_state;
  state_t     nxt_state;

  mcu_stream_buffer u_stream_buffer (
    .clk       (i_master_clk),
    .reset     (i_reset),
    .in_data   (i_master_data),
    .in_valid  (push_valid),
    .out_ready (i_stream_ready),
    .out_data  (o_stream_data),
    .out_valid (o_stream_valid),
    .overflow  (buf_overflow)
  );

  always_comb begin
    status_byte                   = 8'h00;
    status_byte[7:4]              = STATUS_ID;
    status_byte[STS_STREAM_VALID] = o_stream_valid;
    status_byte[STS_OVERFLOW]     = overflow_q;
    status_byte[STS_FRAME_ERR]    = frame_error_q;
  end

  assign addr_bad = (i_master_data >> REG_ADDR_W) != 8'd0;

  always_comb begin
    opcode_d     = opcode_q;
    count_d      = count_q;
    rd_pending_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_valid_d = 1'b0;
    wr_en_d      = 1'b0;
    reg_addr_d   = reg_addr_q;
    wr_data_d    = wr_data_q;
    push_valid   = 1'b0;
    set_err      = 1'b0;
    status_read  = 1'b0;
    cur_state    = state_q;

    // Start takes effect before any byte in the same cycle, so that byte is the opcode.
    if (i_master_start) begin
      if (state_q inside {ST_OPCODE, ST_LENGTH, ST_PAYLOAD}) set_err = 1'b1;
      cur_state = ST_OPCODE;
    end
    nxt_state = cur_state;

    if (rd_pending_q) begin
      resp_data_d  = i_reg_rd_data;
      resp_valid_d = 1'b1;
    end

    if (i_master_data_valid) begin
      case (cur_state)
        ST_OPCODE: begin
          opcode_d = i_master_data;
          if (opcode_known(i_master_data)) begin
            nxt_state = ST_LENGTH;
          end else begin
            set_err   = 1'b1;
            nxt_state = ST_DRAIN;
          end
        end
        ST_LENGTH: begin
          count_d = i_master_data;
          if (!length_ok(opcode_q, i_master_data)) begin
            set_err   = 1'b1;
            nxt_state = ST_DRAIN;
          end else if (opcode_q == OP_STATUS) begin
            resp_data_d  = status_byte;
            resp_valid_d = 1'b1;
            status_read  = 1'b1;
            nxt_state    = ST_DRAIN;
          end else if (i_master_data == 8'd0) begin
            nxt_state = ST_DRAIN;
          end else begin
            nxt_state = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          count_d = count_q - 8'd1;
          if (count_q == 8'd1) nxt_state = ST_DRAIN;
          case (opcode_q)
            OP_STREAM: push_valid = 1'b1;
            OP_WRITE_REG: begin
              if (count_q == LEN_WRITE_REG) begin
                if (addr_bad) begin
                  set_err   = 1'b1;
                  nxt_state = ST_DRAIN;
                end else begin
                  reg_addr_d = i_master_data[REG_ADDR_W-1:0];
                end
              end else begin
                wr_en_d   = 1'b1;
                wr_data_d = i_master_data;
              end
            end
            OP_READ_REG: begin
              if (addr_bad) begin
                set_err = 1'b1;
              end else begin
                reg_addr_d   = i_master_data[REG_ADDR_W-1:0];
                rd_pending_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end

    // End is applied after the same-cycle byte has been consumed.
    if (i_master_end) begin
      if (nxt_state inside {ST_OPCODE, ST_LENGTH, ST_PAYLOAD}) set_err = 1'b1;
      nxt_state = ST_IDLE;
    end
    state_d = nxt_state;

    // Read-to-clear, but a flag raised in the clearing cycle survives.
    frame_error_d = (frame_error_q && !status_read) || set_err;
    overflow_d    = (overflow_q && !status_read) || buf_overflow;
  end

  always_ff @(posedge i_master_clk) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      opcode_q      <= 8'h00;
      count_q       <= 8'h00;
      frame_error_q <= 1'b0;
      overflow_q    <= 1'b0;
      rd_pending_q  <= 1'b0;
      resp_data_q   <= 8'h00;
      resp_valid_q  <= 1'b0;
      wr_en_q       <= 1'b0;
      reg_addr_q    <= '0;
      wr_data_q     <= 8'h00;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      count_q       <= count_d;
      frame_error_q <= frame_error_d;
      overflow_q    <= overflow_d;
      rd_pending_q  <= rd_pending_d;
      resp_data_q   <= resp_data_d;
      resp_valid_q  <= resp_valid_d;
      wr_en_q       <= wr_en_d;
      reg_addr_q    <= reg_addr_d;
      wr_data_q     <= wr_data_d;
    end
  end

  assign o_response_data       = resp_data_q;
  assign o_response_data_valid = resp_valid_q;
  assign o_reg_wr_en           = wr_en_q;
  assign o_reg_addr            = reg_addr_q;
  assign o_reg_wr_data         = wr_data_q;

endmodule

// File: tb/tb_mcu_command_sequencer.sv
// tb/tb_mcu_command_sequencer.sv - directed scoreboard bench for mcu_command_sequencer
module tb_mcu_command_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_start;
  logic       m_end;
  logic [7:0] resp_data;
  logic       resp_valid;
  logic       wr_en;
  logic [3:0] reg_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0]  resp_exp_q[$];
  logic [11:0] wr_exp_q[$];
  logic [7:0]  stream_exp_q[$];

  always #5 clk = ~clk;

  mcu_command_sequencer dut (
    .i_master_clk          (clk),
    .i_reset               (reset),
    .i_master_data         (m_data),
    .i_master_data_valid   (m_valid),
    .i_master_start        (m_start),
    .i_master_end          (m_end),
    .o_response_data       (resp_data),
    .o_response_data_valid (resp_valid),
    .o_reg_wr_en           (wr_en),
    .o_reg_addr            (reg_addr),
    .o_reg_wr_data         (wr_data),
    .i_reg_rd_data         (rd_data),
    .o_stream_data         (s_data),
    .o_stream_valid        (s_valid),
    .i_stream_ready        (s_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Inputs are held across exactly one rising edge.
  task automatic send(input logic [7:0] b, input bit dv, input bit st, input bit en);
    m_data  = b;
    m_valid = dv;
    m_start = st;
    m_end   = en;
    @(posedge clk);
    #1;
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_start = 1'b0;
    m_end   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic status_frame(input logic [7:0] exp);
    send(8'h01, 1'b1, 1'b1, 1'b0);
    resp_exp_q.push_back(exp);
    send(8'h00, 1'b1, 1'b0, 1'b0);
    send(8'h00, 1'b1, 1'b0, 1'b1);
    idle(2);
  endtask

  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (resp_exp_q.size() == 0) check("resp_unexpected", {24'h0, resp_data}, 32'hFFFF_FFFF);
      else check("resp_data", {24'h0, resp_data}, {24'h0, resp_exp_q.pop_front()});
    end
    if (wr_en === 1'b1) begin
      if (wr_exp_q.size() == 0) check("wr_unexpected", {20'h0, reg_addr, wr_data}, 32'hFFFF_FFFF);
      else check("wr_addr_data", {20'h0, reg_addr, wr_data}, {20'h0, wr_exp_q.pop_front()});
    end
    if (s_valid === 1'b1 && s_ready === 1'b1) begin
      if (stream_exp_q.size() == 0) check("stream_unexpected", {24'h0, s_data}, 32'hFFFF_FFFF);
      else check("stream_data", {24'h0, s_data}, {24'h0, stream_exp_q.pop_front()});
    end
  end

  initial begin
    reset   = 1'b1;
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_start = 1'b0;
    m_end   = 1'b0;
    rd_data = 8'hEE;
    s_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_outputs", {resp_data, 3'b0, resp_valid, 3'b0, wr_en, reg_addr, wr_data},
          32'h0);
    check("reset_stream", {23'h0, s_valid, s_data}, 32'h0);
    @(posedge clk);
    #1;

    // STATUS with a trailing dummy byte
    status_frame(8'hA0);
    check("status_trailing_no_err", {31'h0, dut.frame_error_q}, 32'h0);

    // WRITE_REG 5 <= 0x3C, then clean status
    wr_exp_q.push_back({4'h5, 8'h3C});
    send(8'h02, 1'b1, 1'b1, 1'b0);
    send(8'h02, 1'b1, 1'b0, 1'b0);
    send(8'h05, 1'b1, 1'b0, 1'b0);
    send(8'h3C, 1'b1, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0, 1'b1);
    idle(2);
    status_frame(8'hA0);

    // READ_REG 7, last byte shares its cycle with end
    rd_data = 8'h5A;
    resp_exp_q.push_back(8'h5A);
    send(8'h03, 1'b1, 1'b1, 1'b0);
    send(8'h01, 1'b1, 1'b0, 1'b0);
    send(8'h07, 1'b1, 1'b0, 1'b0);
    send(8'h00, 1'b1, 1'b0, 1'b1);
    idle(2);
    check("read_addr", {28'h0, reg_addr}, 32'h7);
    check("read_resp_done", resp_exp_q.size(), 32'h0);
    rd_data = 8'hEE;

    // Truncated WRITE_REG: no commit, error read then cleared
    send(8'h02, 1'b1, 1'b1, 1'b0);
    send(8'h02, 1'b1, 1'b0, 1'b0);
    send(8'h05, 1'b1, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0, 1'b1);
    idle(2);
    status_frame(8'hA1);
    status_frame(8'hA0);

    // Stream with a stalled sink: first byte held, rest overflow
    stream_exp_q.push_back(8'h11);
    send(8'h10, 1'b1, 1'b1, 1'b0);
    send(8'h03, 1'b1, 1'b0, 1'b0);
    send(8'h11, 1'b1, 1'b0, 1'b0);
    send(8'h22, 1'b1, 1'b0, 1'b0);
    send(8'h33, 1'b1, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0, 1'b1);
    idle(2);
    check("stream_held", {23'h0, s_valid, s_data}, {23'h0, 1'b1, 8'h11});
    status_frame(8'hA6);
    s_ready = 1'b1;
    idle(3);
    check("stream_sink_once", stream_exp_q.size(), 32'h0);
    check("stream_empty", {31'h0, s_valid}, 32'h0);
    status_frame(8'hA0);

    // Pass-through reload with the sink always ready
    stream_exp_q.push_back(8'h44);
    stream_exp_q.push_back(8'h55);
    send(8'h10, 1'b1, 1'b1, 1'b0);
    send(8'h02, 1'b1, 1'b0, 1'b0);
    send(8'h44, 1'b1, 1'b0, 1'b0);
    send(8'h55, 1'b1, 1'b0, 1'b1);
    idle(3);
    check("passthru_done", stream_exp_q.size(), 32'h0);
    status_frame(8'hA0);

    // Restart mid-frame flags an error seen by the new STATUS
    send(8'h02, 1'b1, 1'b1, 1'b0);
    send(8'h02, 1'b1, 1'b0, 1'b0);
    status_frame(8'hA1);

    // Unknown opcode, reset during drain
    send(8'h7F, 1'b1, 1'b1, 1'b0);
    send(8'hAA, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    send(8'hBB, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_outputs", {resp_data, 3'b0, resp_valid, 3'b0, wr_en, reg_addr, wr_data},
          32'h0);
    check("midreset_stream", {23'h0, s_valid, s_data}, 32'h0);
    @(posedge clk);
    #1;
    // Bytes without a start must be ignored after reset
    send(8'h01, 1'b1, 1'b0, 1'b0);
    send(8'h00, 1'b1, 1'b0, 1'b0);
    idle(2);
    status_frame(8'hA0);

    idle(4);
    check("resp_queue_empty", resp_exp_q.size(), 32'h0);
    check("wr_queue_empty", wr_exp_q.size(), 32'h0);
    check("stream_queue_empty", stream_exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
